// File: rtl/int_bus_rr_arbiter.sv
// Round-robin arbiter and mux for the shared internal register bus.
// One master owns the slave bus at a time; a hold limit forces handover when others wait.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | no grant; pick the next requester from rr_ptr upward
//   ST_GRANT | owner drives the slave bus while it keeps its request up
module int_bus_rr_arbiter #(
   parameter int NUM_MASTERS = 4,
   parameter int AW          = 16,
   parameter int DW          = 8,
   parameter int MAX_HOLD    = 16
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic [NUM_MASTERS-1:0]          m_req,
   output logic [NUM_MASTERS-1:0]          m_gnt,
   input  logic [NUM_MASTERS*AW-1:0]       m_address,
   input  logic [NUM_MASTERS*DW-1:0]       m_wr_data,
   input  logic [NUM_MASTERS-1:0]          m_write,
   input  logic [NUM_MASTERS-1:0]          m_read,
   output logic [DW-1:0]                   m_rd_data,
   output logic [AW-1:0]                   s_address,
   output logic [DW-1:0]                   s_wr_data,
   output logic                            s_write,
   output logic                            s_read,
   input  logic [DW-1:0]                   s_rd_data,
   output logic                            busy,
   output logic [$clog2(NUM_MASTERS)-1:0]  owner
);

   localparam int OW = $clog2(NUM_MASTERS);
   localparam int HW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);

   typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;

   state_t                 state_q, state_d;
   logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
   logic [OW-1:0]          owner_q, owner_d;
   logic [OW-1:0]          rr_ptr_q, rr_ptr_d;
   logic [HW-1:0]          hold_cnt_q, hold_cnt_d;

   logic                   win_found;
   logic [OW-1:0]          win_idx;
   logic [OW-1:0]          cand;
   logic                   others_req;
   logic                   hold_limit;
   logic                   release_now;

   logic [AW-1:0]          addr_arr [NUM_MASTERS];
   logic [DW-1:0]          wdat_arr [NUM_MASTERS];

   for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
      assign addr_arr[i] = m_address[i*AW +: AW];
      assign wdat_arr[i] = m_wr_data[i*DW +: DW];
   end

   // First requester at or above rr_ptr, wrapping around.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         cand = OW'((int'(rr_ptr_q) + k) % NUM_MASTERS);
         if (!win_found && m_req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   assign others_req  = |(m_req & ~gnt_q);
   assign hold_limit  = (MAX_HOLD != 0) && (hold_cnt_q == HW'(MAX_HOLD));
   assign release_now = !m_req[owner_q] || (hold_limit && others_req);

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         gnt_q      <= '0;
         owner_q    <= '0;
         rr_ptr_q   <= '0;
         hold_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         owner_q    <= owner_d;
         rr_ptr_q   <= rr_ptr_d;
         hold_cnt_q <= hold_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      owner_d    = owner_q;
      rr_ptr_d   = rr_ptr_q;
      hold_cnt_d = hold_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (win_found) begin
               state_d    = ST_GRANT;
               gnt_d      = NUM_MASTERS'(1) << win_idx;
               owner_d    = win_idx;
               rr_ptr_d   = OW'((int'(win_idx) + 1) % NUM_MASTERS);
               hold_cnt_d = HW'(1);
            end
         end
         ST_GRANT: begin
            // Releasing always passes through IDLE, giving one dead cycle per handover.
            if (release_now) begin
               state_d = ST_IDLE;
               gnt_d   = '0;
            end else if (MAX_HOLD != 0 && hold_cnt_q != HW'(MAX_HOLD)) begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign m_gnt     = gnt_q;
   assign owner     = owner_q;
   assign m_rd_data = s_rd_data;

   always_comb begin
      busy      = (state_q == ST_GRANT);
      s_address = '0;
      s_wr_data = '0;
      s_write   = 1'b0;
      s_read    = 1'b0;
      if (state_q == ST_GRANT) begin
         s_address = addr_arr[owner_q];
         s_wr_data = wdat_arr[owner_q];
         s_write   = m_write[owner_q];
         s_read    = m_read[owner_q] & ~m_write[owner_q];
      end
   end

   a_gnt_onehot : assert property (@(posedge clock) disable iff (!reset) $onehot0(m_gnt));
   a_strobe_excl : assert property (@(posedge clock) disable iff (!reset) !(s_write && s_read));

endmodule

// File: tb/tb_int_bus_rr_arbiter.sv
// Bench for int_bus_rr_arbiter: directed scenarios plus randomized traffic,
// all checked through a scoreboard fed by a cycle-level reference model.
module tb_int_bus_rr_arbiter;

   localparam int N    = 4;
   localparam int AW   = 16;
   localparam int DW   = 8;
   localparam int MAXH = 16;

   logic              clock = 1'b0;
   logic              reset;
   logic [N-1:0]      m_req, m_gnt, m_write, m_read;
   logic [N*AW-1:0]   m_address;
   logic [N*DW-1:0]   m_wr_data;
   logic [DW-1:0]     m_rd_data, s_wr_data, s_rd_data;
   logic [AW-1:0]     s_address;
   logic              s_write, s_read, busy;
   logic [1:0]        owner;

   int_bus_rr_arbiter #(.NUM_MASTERS(N), .AW(AW), .DW(DW), .MAX_HOLD(MAXH)) dut (
      .clock(clock), .reset(reset), .m_req(m_req), .m_gnt(m_gnt),
      .m_address(m_address), .m_wr_data(m_wr_data), .m_write(m_write), .m_read(m_read),
      .m_rd_data(m_rd_data), .s_address(s_address), .s_wr_data(s_wr_data),
      .s_write(s_write), .s_read(s_read), .s_rd_data(s_rd_data),
      .busy(busy), .owner(owner)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [N-1:0]  gnt;
      int            owner;
      logic          busy;
      logic [AW-1:0] addr;
      logic [DW-1:0] wd;
      logic          wr;
      logic          rd;
      logic [DW-1:0] rdd;
   } exp_t;

   exp_t sb_q[$];
   int   vectors     = 0;
   int   miscompares = 0;

   // Reference model: who holds the bus, for how long, and where the next search starts.
   int   holder      = -1;
   int   last_owner  = 0;
   int   next_start  = 0;
   int   held        = 0;
   bit   model_valid = 0;

   int   glog_idx[$];
   int   glog_len[$];
   int   cur_len = 0;
   logic [N-1:0] prev_gnt = '0;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic int gnt_idx(logic [N-1:0] g);
      for (int i = 0; i < N; i++) if (g[i]) return i;
      return -1;
   endfunction

   function automatic exp_t predict();
      exp_t e;
      e.gnt   = (holder >= 0) ? (N'(1) << holder) : '0;
      e.owner = last_owner;
      e.busy  = (holder >= 0);
      e.addr  = '0;
      e.wd    = '0;
      e.wr    = 1'b0;
      e.rd    = 1'b0;
      e.rdd   = s_rd_data;
      if (holder >= 0) begin
         e.addr = m_address[holder*AW +: AW];
         e.wd   = m_wr_data[holder*DW +: DW];
         e.wr   = m_write[holder];
         e.rd   = m_read[holder] && !m_write[holder];
      end
      return e;
   endfunction

   task automatic model_edge();
      bit others;
      if (!reset) begin
         holder = -1; next_start = 0; last_owner = 0; held = 0; model_valid = 1;
      end else if (model_valid) begin
         if (holder < 0) begin
            for (int k = 0; k < N; k++) begin
               if (holder < 0 && m_req[(next_start + k) % N]) holder = (next_start + k) % N;
            end
            if (holder >= 0) begin
               last_owner = holder;
               next_start = (holder + 1) % N;
               held       = 1;
            end
         end else begin
            others = 0;
            for (int i = 0; i < N; i++) if (i != holder && m_req[i]) others = 1;
            if (!m_req[holder] || (MAXH != 0 && held >= MAXH && others)) holder = -1;
            else held++;
         end
      end
   endtask

   task automatic step();
      if (model_valid) sb_q.push_back(predict());
      @(posedge clock);
      model_edge();
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      m_req = '0;
      step();
      step();
      reset = 1'b1;
      glog_idx.delete();
      glog_len.delete();
   endtask

   always @(negedge clock) begin
      exp_t e;
      int   gi;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk("m_gnt", m_gnt, e.gnt);
         chk("owner", owner, e.owner);
         chk("busy", busy, e.busy);
         chk("s_address", s_address, e.addr);
         chk("s_wr_data", s_wr_data, e.wd);
         chk("s_write", s_write, e.wr);
         chk("s_read", s_read, e.rd);
         chk("m_rd_data", m_rd_data, e.rdd);
         chk("handover_gap", (prev_gnt == 0 || m_gnt == 0 || m_gnt == prev_gnt), 1);
         gi = gnt_idx(m_gnt);
         if (m_gnt != 0 && prev_gnt == 0) begin
            glog_idx.push_back(gi);
            cur_len = 1;
         end else if (m_gnt != 0) begin
            cur_len++;
         end else if (prev_gnt != 0) begin
            glog_len.push_back(cur_len);
         end
         prev_gnt = m_gnt;
      end
   end

   initial begin
      int  hold;
      bit  raise2;
      reset     = 1'b0;
      m_req     = 4'b1111;
      m_write   = '0;
      m_read    = '0;
      m_address = '0;
      m_wr_data = '0;
      s_rd_data = '0;
      #1;

      // Reset held for two cycles with every master requesting.
      step();
      step();
      reset = 1'b1;
      step();
      chk("t1_gnt_after_release", m_gnt, 4'b0001);

      // Each master drops its request after 3 grant cycles, then re-raises it.
      do_reset();
      hold = 0;
      for (int c = 0; c < 20; c++) begin
         if (m_gnt != 0) hold++; else hold = 0;
         m_req = 4'b1111;
         if (hold == 3) m_req[gnt_idx(m_gnt)] = 1'b0;
         step();
      end
      chk("t2_grant_count", glog_idx.size() >= 5, 1);
      if (glog_idx.size() >= 5 && glog_len.size() >= 4) begin
         for (int i = 0; i < 5; i++) chk("t2_order", glog_idx[i], i % N);
         for (int i = 0; i < 4; i++) chk("t2_len", glog_len[i], 3);
      end

      // Master 1 holds; master 2 joins at grant cycle 5 and forces a handover at MAX_HOLD.
      do_reset();
      hold   = 0;
      raise2 = 0;
      for (int c = 0; c < 20; c++) begin
         if (m_gnt != 0) hold++; else hold = 0;
         if (m_gnt[1] && hold == 5) raise2 = 1;
         m_req = {1'b0, raise2, 1'b1, 1'b0};
         step();
      end
      chk("t3_grant_count", glog_idx.size() >= 2 && glog_len.size() >= 1, 1);
      if (glog_idx.size() >= 2 && glog_len.size() >= 1) begin
         chk("t3_first_owner", glog_idx[0], 1);
         chk("t3_hold_len", glog_len[0], MAXH);
         chk("t3_second_owner", glog_idx[1], 2);
      end

      // Granted master's strobes reach the slave bus; others are ignored.
      do_reset();
      m_address[2*AW +: AW] = 16'h1234;
      m_wr_data[2*DW +: DW] = 8'hA5;
      m_address[0 +: AW]    = 16'hBEEF;
      m_wr_data[0 +: DW]    = 8'h11;
      m_write               = 4'b0101;
      m_req                 = 4'b0100;
      step();
      chk("t4_gnt", m_gnt, 4'b0100);
      chk("t4_s_address", s_address, 16'h1234);
      chk("t4_s_wr_data", s_wr_data, 8'hA5);
      chk("t4_s_write", s_write, 1);
      step();

      // Simultaneous read and write: write wins; read data is broadcast.
      m_read[2] = 1'b1;
      s_rd_data = 8'h3C;
      #1;
      chk("t5_s_write", s_write, 1);
      chk("t5_s_read", s_read, 0);
      chk("t5_m_rd_data", m_rd_data, 8'h3C);
      step();
      m_write[2] = 1'b0;
      #1;
      chk("t5_read_only", s_read, 1);
      step();

      // Reset mid-grant clears the grant and the round-robin pointer.
      do_reset();
      m_write = '0;
      m_read  = '0;
      m_req   = 4'b1000;
      step();
      step();
      chk("t6_gnt_m3", m_gnt, 4'b1000);
      reset = 1'b0;
      m_req = 4'b1111;
      step();
      chk("t6_gnt_in_reset", m_gnt, 4'b0000);
      chk("t6_busy_in_reset", busy, 0);
      reset = 1'b1;
      step();
      chk("t6_gnt_after_release", m_gnt, 4'b0001);
      chk("t6_owner_after_release", owner, 0);

      // Randomized traffic with persistent requests and rare resets.
      m_req = '0;
      for (int c = 0; c < 3000; c++) begin
         reset = ($urandom_range(199) == 0) ? 1'b0 : 1'b1;
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(9) == 0) m_req[i] = ~m_req[i];
            m_address[i*AW +: AW] = AW'($urandom);
            m_wr_data[i*DW +: DW] = DW'($urandom);
            m_write[i]            = $urandom_range(1) == 1;
            m_read[i]             = $urandom_range(1) == 1;
         end
         s_rd_data = DW'($urandom);
         step();
      end

      reset = 1'b1;
      m_req = '0;
      step();
      @(posedge clock);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
